// File: rtl/env_alarm_monitor.sv
// Multi-channel threshold alarm engine with confirmation, hysteresis, ack-to-mute and buzzer tone.
// Optional build macro ALARM_LATCH_EN: alarms latch until acknowledged after the hysteresis exit.
module env_alarm_monitor #(
   parameter int CH_NUM      = 2,
   parameter int DATA_W      = 12,
   parameter int CONFIRM_CNT = 3,
   parameter int HYST        = 2,
   parameter int TONE_HALF   = 12500
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [CH_NUM*DATA_W-1:0] din,
   input  logic                     din_valid,
   input  logic [CH_NUM*DATA_W-1:0] th_hi,
   input  logic [CH_NUM*DATA_W-1:0] th_lo,
   input  logic                     ack,
   output logic [CH_NUM-1:0]        alarm_hi,
   output logic [CH_NUM-1:0]        alarm_lo,
   output logic                     alarm_any,
   output logic                     muted,
   output logic                     beep
);

   typedef enum logic [2:0] {NORMAL, HI_PEND, HI_ALARM, LO_PEND, LO_ALARM} state_t;

   localparam int               TONE_W    = (TONE_HALF > 2) ? $clog2(TONE_HALF) : 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
   localparam logic [3:0]        CONFIRM_V = 4'(CONFIRM_CNT);
   localparam logic [DATA_W-1:0] HYST_V    = DATA_W'(HYST);

   state_t            state_q [CH_NUM];
   state_t            state_d [CH_NUM];
   logic [3:0]        cnt_q   [CH_NUM];
   logic [3:0]        cnt_d   [CH_NUM];
   logic [CH_NUM-1:0] alarm_hi_q, alarm_hi_d, alarm_lo_q, alarm_lo_d;
   logic              alarm_any_q, alarm_any_d, muted_q, muted_d, beep_q, beep_d;
   logic [TONE_W-1:0] tone_q, tone_d;
   logic [CH_NUM-1:0] hiV, loV, hiExit, loExit;
   logic              alarmRise, soundingQ, soundingD;
`ifdef ALARM_LATCH_EN
   logic [CH_NUM-1:0] cleared_q, cleared_d;
`endif

   // Per-channel violation and hysteresis-exit comparisons with saturating limits.
   for (genvar k = 0; k < CH_NUM; k++) begin : g_cmp
      logic [DATA_W-1:0] sample, thHi, thLo, hiLim, loLim;
      logic [DATA_W:0]   loSum;
      assign sample    = din[k*DATA_W +: DATA_W];
      assign thHi      = th_hi[k*DATA_W +: DATA_W];
      assign thLo      = th_lo[k*DATA_W +: DATA_W];
      assign hiLim     = (thHi < HYST_V) ? '0 : thHi - HYST_V;
      assign loSum     = {1'b0, thLo} + {1'b0, HYST_V};
      assign loLim     = loSum[DATA_W] ? '1 : loSum[DATA_W-1:0];
      assign hiV[k]    = (sample >= thHi);
      assign loV[k]    = (sample < thLo) && !hiV[k];
      assign hiExit[k] = (sample <= hiLim);
      assign loExit[k] = (sample >= loLim);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int k = 0; k < CH_NUM; k++) begin
            state_q[k] <= NORMAL;
            cnt_q[k]   <= '0;
         end
         alarm_hi_q  <= '0;
         alarm_lo_q  <= '0;
         alarm_any_q <= 1'b0;
         muted_q     <= 1'b0;
         beep_q      <= 1'b0;
         tone_q      <= '0;
`ifdef ALARM_LATCH_EN
         cleared_q   <= '0;
`endif
      end else begin
         for (int k = 0; k < CH_NUM; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         alarm_hi_q  <= alarm_hi_d;
         alarm_lo_q  <= alarm_lo_d;
         alarm_any_q <= alarm_any_d;
         muted_q     <= muted_d;
         beep_q      <= beep_d;
         tone_q      <= tone_d;
`ifdef ALARM_LATCH_EN
         cleared_q   <= cleared_d;
`endif
      end
   end

   always_comb begin
      for (int k = 0; k < CH_NUM; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
`ifdef ALARM_LATCH_EN
         cleared_d[k] = cleared_q[k];
`endif
         if (din_valid) begin
            case (state_q[k])
               NORMAL, HI_PEND, LO_PEND: begin
                  if (hiV[k]) begin
                     cnt_d[k]   = (state_q[k] == HI_PEND) ? cnt_q[k] + 4'd1 : 4'd1;
                     state_d[k] = (cnt_d[k] == CONFIRM_V) ? HI_ALARM : HI_PEND;
                  end else if (loV[k]) begin
                     cnt_d[k]   = (state_q[k] == LO_PEND) ? cnt_q[k] + 4'd1 : 4'd1;
                     state_d[k] = (cnt_d[k] == CONFIRM_V) ? LO_ALARM : LO_PEND;
                  end else begin
                     cnt_d[k]   = '0;
                     state_d[k] = NORMAL;
                  end
               end
`ifdef ALARM_LATCH_EN
               HI_ALARM: begin
                  if (hiV[k])         cleared_d[k] = 1'b0;
                  else if (hiExit[k]) cleared_d[k] = 1'b1;
               end
               LO_ALARM: begin
                  if (loV[k])         cleared_d[k] = 1'b0;
                  else if (loExit[k]) cleared_d[k] = 1'b1;
               end
`else
               HI_ALARM: begin
                  if (hiExit[k]) begin
                     state_d[k] = NORMAL;
                     cnt_d[k]   = '0;
                  end
               end
               LO_ALARM: begin
                  if (loExit[k]) begin
                     state_d[k] = NORMAL;
                     cnt_d[k]   = '0;
                  end
               end
`endif
               default: begin
                  state_d[k] = NORMAL;
                  cnt_d[k]   = '0;
               end
            endcase
         end
`ifdef ALARM_LATCH_EN
         // A channel that has recovered waits for the operator's ack before returning to NORMAL.
         if (ack && cleared_d[k]) begin
            state_d[k]   = NORMAL;
            cnt_d[k]     = '0;
            cleared_d[k] = 1'b0;
         end
`endif
      end
   end

   // A newly raised alarm always overrides a mute, even one requested in the same cycle.
   always_comb begin
      for (int k = 0; k < CH_NUM; k++) begin
         alarm_hi_d[k] = (state_d[k] == HI_ALARM);
         alarm_lo_d[k] = (state_d[k] == LO_ALARM);
      end
      alarm_any_d = |{alarm_hi_d, alarm_lo_d};
      alarmRise   = |({alarm_hi_d, alarm_lo_d} & ~{alarm_hi_q, alarm_lo_q});
      muted_d     = muted_q;
      if (alarmRise || !alarm_any_d) muted_d = 1'b0;
      else if (ack && alarm_any_q)   muted_d = 1'b1;
      soundingQ = alarm_any_q & ~muted_q;
      soundingD = alarm_any_d & ~muted_d;
      tone_d    = '0;
      beep_d    = 1'b0;
      if (soundingD && soundingQ) begin
         if (tone_q == TONE_LAST) begin
            tone_d = '0;
            beep_d = ~beep_q;
         end else begin
            tone_d = tone_q + 1'b1;
            beep_d = beep_q;
         end
      end
   end

   assign alarm_hi  = alarm_hi_q;
   assign alarm_lo  = alarm_lo_q;
   assign alarm_any = alarm_any_q;
   assign muted     = muted_q;
   assign beep      = beep_q;

endmodule

// File: tb/tb_env_alarm_monitor.sv
// Directed self-checking bench for env_alarm_monitor (short tone period for quick beep checks).
// Covers the latched variant too when built with ALARM_LATCH_EN.
module tb_env_alarm_monitor;

   localparam int DW = 12;
   localparam int TH = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic [2*DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic [2*DW-1:0] th_hi = '0;
   logic [2*DW-1:0] th_lo = '0;
   logic          ack = 1'b0;
   logic [1:0]    alarm_hi, alarm_lo;
   logic          alarm_any, muted, beep;
   int            checks = 0;
   int            errors = 0;

   env_alarm_monitor #(
      .CH_NUM(2), .DATA_W(DW), .CONFIRM_CNT(3), .HYST(2), .TONE_HALF(TH)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din), .din_valid(din_valid),
      .th_hi(th_hi), .th_lo(th_lo), .ack(ack), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
      .alarm_any(alarm_any), .muted(muted), .beep(beep)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One din_valid pulse; returns on the falling edge after the sampling edge.
   task automatic applyStimulus(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      @(negedge sys_clk);
      din       = {d1, d0};
      din_valid = 1'b1;
      @(negedge sys_clk);
      din_valid = 1'b0;
   endtask

   task automatic pulseAck();
      @(negedge sys_clk);
      ack = 1'b1;
      @(negedge sys_clk);
      ack = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_hi"}, 32'(alarm_hi), 0);
      checkOutput({tag, "_lo"}, 32'(alarm_lo), 0);
      checkOutput({tag, "_any"}, 32'(alarm_any), 0);
      checkOutput({tag, "_muted"}, 32'(muted), 0);
      checkOutput({tag, "_beep"}, 32'(beep), 0);
   endtask

   task automatic asyncResetPulse(input string tag);
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 checkAllZero(tag);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      th_hi = {12'd4000, 12'd300};
      th_lo = {12'd100, 12'd100};
      din   = {12'd1000, 12'd200};
      waitCycles(2);
      checkAllZero("reset");
      sys_rst_n = 1'b1;

      pulseAck();
      checkOutput("ack_idle_ignored", 32'(muted), 0);

      applyStimulus(310, 1000);
      checkOutput("confirm_1", 32'(alarm_hi), 0);
      applyStimulus(310, 1000);
      checkOutput("confirm_2", 32'(alarm_hi), 0);
      applyStimulus(310, 1000);
      checkOutput("confirm_3", 32'(alarm_hi), 1);
      checkOutput("confirm_any", 32'(alarm_any), 1);
      waitCycles(TH - 1);
      checkOutput("beep_before_half", 32'(beep), 0);
      waitCycles(1);
      checkOutput("beep_first_high", 32'(beep), 1);
      waitCycles(TH);
      checkOutput("beep_toggle_low", 32'(beep), 0);

`ifdef ALARM_LATCH_EN
      applyStimulus(250, 1000);
      checkOutput("latch_hold", 32'(alarm_hi), 1);
      pulseAck();
      checkOutput("latch_ack_hi", 32'(alarm_hi), 0);
      checkOutput("latch_ack_muted", 32'(muted), 0);
      checkOutput("latch_ack_any", 32'(alarm_any), 0);
      applyStimulus(310, 1000);
      asyncResetPulse("rst_pend");
      applyStimulus(310, 1000);
      applyStimulus(310, 1000);
      checkOutput("rst_pend_cnt_cleared", 32'(alarm_hi), 0);
      applyStimulus(310, 1000);
      checkOutput("rst_pend_realarm", 32'(alarm_hi), 1);
`else
      applyStimulus(299, 1000);
      checkOutput("hyst_band_hold", 32'(alarm_hi), 1);
      applyStimulus(298, 1000);
      checkOutput("hyst_exit_hi", 32'(alarm_hi), 0);
      checkOutput("hyst_exit_any", 32'(alarm_any), 0);
      checkOutput("hyst_exit_beep", 32'(beep), 0);

      applyStimulus(310, 1000);
      applyStimulus(310, 1000);
      applyStimulus(290, 1000);
      checkOutput("glitch_290", 32'(alarm_hi), 0);
      applyStimulus(310, 1000);
      applyStimulus(310, 1000);
      checkOutput("glitch_restart_2", 32'(alarm_hi), 0);
      applyStimulus(310, 1000);
      checkOutput("glitch_restart_3", 32'(alarm_hi), 1);

      th_hi[DW-1:0] = 12'd1;
      applyStimulus(1, 1000);
      checkOutput("sat_hi_hold", 32'(alarm_hi), 1);
      applyStimulus(0, 1000);
      checkOutput("sat_hi_exit", 32'(alarm_hi), 0);
      th_hi[DW-1:0] = 12'd300;

      for (int i = 0; i < 3; i++) applyStimulus(310, 1000);
      checkOutput("mute_alarm", 32'(alarm_hi), 1);
      waitCycles(3);
      pulseAck();
      checkOutput("mute_set", 32'(muted), 1);
      checkOutput("mute_beep", 32'(beep), 0);
      th_lo[2*DW-1:DW] = 12'd200;
      applyStimulus(310, 150);
      applyStimulus(310, 150);
      checkOutput("mute_hold", 32'(muted), 1);
      applyStimulus(310, 150);
      checkOutput("rearm_lo", 32'(alarm_lo), 2);
      checkOutput("rearm_muted", 32'(muted), 0);
      waitCycles(TH - 1);
      checkOutput("rearm_beep_wait", 32'(beep), 0);
      waitCycles(1);
      checkOutput("rearm_beep_high", 32'(beep), 1);
      applyStimulus(200, 202);
      checkOutput("both_exit_any", 32'(alarm_any), 0);

      th_lo[DW-1:0] = 12'd500;
      th_hi[DW-1:0] = 12'd100;
      for (int i = 0; i < 3; i++) applyStimulus(300, 1000);
      checkOutput("prio_hi", 32'(alarm_hi), 1);
      checkOutput("prio_lo", 32'(alarm_lo), 0);
      th_lo[DW-1:0] = 12'd100;
      th_hi[DW-1:0] = 12'd300;
      applyStimulus(200, 1000);
      checkOutput("prio_exit", 32'(alarm_hi), 0);

      th_lo[2*DW-1:DW] = 12'd4095;
      th_hi[2*DW-1:DW] = 12'd4095;
      for (int i = 0; i < 3; i++) applyStimulus(200, 4000);
      checkOutput("sat_lo_alarm", 32'(alarm_lo), 2);
      applyStimulus(200, 4094);
      checkOutput("sat_lo_hold", 32'(alarm_lo), 2);
      applyStimulus(200, 4095);
      checkOutput("sat_lo_exit", 32'(alarm_lo), 0);
      th_lo[2*DW-1:DW] = 12'd100;
      th_hi[2*DW-1:DW] = 12'd4000;

      for (int i = 0; i < 3; i++) applyStimulus(310, 1000);
      checkOutput("rst_alarm_pre", 32'(alarm_hi), 1);
      asyncResetPulse("rst_alarm");
      applyStimulus(310, 1000);
      checkOutput("rst_alarm_after", 32'(alarm_hi), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/env_alarm_monitor.md
# env_alarm_monitor

Multi-channel threshold alarm engine for the temperature/humidity sensor path. It sits after the per-channel averaging filters and replaces the single-threshold comparators and the free-running buzzer enable. Each channel has programmable high and low limits, hysteresis and N-sample confirmation. The block drives per-channel alarm flags and a gated buzzer tone, and the key flag acknowledges (silences) the buzzer.

## Interface
Parameters:
- CH_NUM, 2, number of monitored channels
- DATA_W, 12, unsigned sample width per channel
- CONFIRM_CNT, 3, consecutive violating samples needed to raise an alarm (1..15)
- HYST, 2, hysteresis in LSBs applied on alarm exit
- TONE_HALF, 12500, sys_clk cycles per buzzer half-period (2 kHz at 50 MHz)

Ports:
- sys_clk  in  1  system clock, 50 MHz; only clock
- sys_rst_n  in  1  asynchronous active-low reset
- din  in  CH_NUM*DATA_W  packed samples; channel k at [k*DATA_W +: DATA_W]
- din_valid  in  1  one-cycle pulse; all channels sampled together
- th_hi  in  CH_NUM*DATA_W  per-channel high limit, packed like din
- th_lo  in  CH_NUM*DATA_W  per-channel low limit, packed like din
- ack  in  1  one-cycle pulse from key_filter key_flag
- alarm_hi  out  CH_NUM  channel in high alarm
- alarm_lo  out  CH_NUM  channel in low alarm
- alarm_any  out  1  OR of all alarm bits
- muted  out  1  buzzer silenced by ack
- beep  out  1  buzzer drive, square wave while sounding

## Operation
- Each channel has its own FSM: NORMAL, HI_PEND, HI_ALARM, LO_PEND, LO_ALARM. It also has a 4-bit confirm counter cnt.
- The FSM advances only on the din_valid cycle. Thresholds are read on that cycle only.
- Violation conditions: hi_v = din >= th_hi; lo_v = din < th_lo. If both are true (misconfigured limits), hi_v wins.
- NORMAL:
  - hi_v: cnt=1, go to HI_PEND, or straight to HI_ALARM if CONFIRM_CNT==1.
  - lo_v: same, for the LO path.
- HI_PEND:
  - hi_v: cnt+1. Go to HI_ALARM when cnt+1 == CONFIRM_CNT.
  - lo_v: restart on the LO path with cnt=1.
  - Neither: go to NORMAL, cnt=0.
- LO_PEND mirrors HI_PEND.
- HI_ALARM exits to NORMAL when din <= th_hi - HYST. The subtraction saturates at 0.
- LO_ALARM exits to NORMAL when din >= th_lo + HYST. The addition saturates at 2^DATA_W-1.
- Inside the hysteresis band the alarm holds.
- alarm_hi[k] = (state==HI_ALARM); alarm_lo[k] = (state==LO_ALARM). Both are registered.
- Mute behaviour:
  - ack while alarm_any=1 sets muted. ack while alarm_any=0 is ignored.
  - muted clears when alarm_any falls.
  - muted also clears when any alarm bit rises (0→1) on a channel. This applies even in the same cycle as an ack; the new alarm wins.
- Tone generator:
  - Sounding = alarm_any & ~muted.
  - While sounding, a counter counts 0..TONE_HALF-1 and toggles beep at wrap.
  - While not sounding, the counter and beep are forced to 0.

## Timing
- Reset value of every register is 0: states NORMAL, cnt, alarm_hi, alarm_lo, alarm_any, muted, beep, tone counter.
- Reset may arrive mid-pending or mid-alarm. Everything returns to the reset values immediately, since reset is asynchronous.
- Alarm bits update on the clock edge that samples din_valid. They are visible one cycle after the din_valid cycle.
- alarm_any is registered from the next-state alarm bits, so it is coincident with the alarm bits.
- muted updates one cycle after ack.
- beep first goes high TONE_HALF cycles after sounding starts. It drops to 0 in the cycle after sounding ends.
- Back-to-back din_valid pulses on consecutive cycles are legal; each one is a sample.

## Configuration
- ALARM_LATCH_EN defined:
  - HI_ALARM and LO_ALARM do not self-clear.
  - The hysteresis exit condition sets a per-channel cleared flag.
  - An ack pulse returns all cleared channels to NORMAL.
  - On that same ack, muted is set only if some alarm remains uncleared.
  - A new violation sample in alarm resets cleared.
- ALARM_LATCH_EN undefined: alarms self-clear as described in Operation. No cleared flags are synthesised.

## Test plan
- Confirmation: CH0 th_hi=300. Send din 310, 310, 310 → alarm_hi[0]=1 one cycle after the 3rd din_valid, not before. beep toggles every 12500 cycles.
- Glitch reject: samples 310, 310, 290, 310 → no alarm. cnt returns to 0 on 290, then becomes 1 again.
- Hysteresis, non-latched: in HI_ALARM with th_hi=300, HYST=2:
  - sample 299 → alarm holds.
  - sample 298 → alarm_hi[0]=0, beep=0 the next cycle.
  - th_hi=1: sample 0 clears (saturating).
- Mute and re-arm:
  - CH0 in alarm; ack → muted=1, beep=0.
  - Then CH1 low alarm (th_lo=200, 3 samples of 150) → muted=0, beep resumes.
- Priority and saturation:
  - th_lo=500, th_hi=100, din=300 → HI path taken.
  - th_lo=4095, HYST=2 in LO_ALARM → exit only at din=4095.
- Latch mode (ALARM_LATCH_EN):
  - Alarm, then sample 250 (cleared) → alarm_hi stays 1.
  - ack → alarm_hi=0, muted=0.
  - Reset pulse mid-HI_PEND → all outputs 0.
